elastic_async_operator: RTL and testbench
=========================================

ELASTIC_ASYNC_OPERATOR -- requirements
Module: elastic_async_operator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter INPUT_SIZE, default 2, operand count; legal range 1..3.
REQ-003 SHALL have parameter OUTPUT_SIZE, default 2, independent consumer ports; legal range 1..4.
REQ-004 SHALL have parameter DEPTH, default 4, per-input FIFO depth; power of two, >=2.
REQ-005 SHALL have parameter OP, default "add"; one of "reg","in","out","addi","subi","muli","add","sub","mul","min","max".
REQ-006 SHALL have parameter IMMEDIATE, default 0, constant for *i ops.
REQ-007 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-008 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-009 SHALL have port req_l  output  INPUT_SIZE  per-input pull request to producer, registered.
REQ-010 SHALL have port ack_l  input  INPUT_SIZE  per-input producer acknowledge; din slice valid with it.
REQ-011 SHALL have port din  input  DATA_WIDTH*INPUT_SIZE  operand k in bits [DW*(k+1)-1:DW*k].
REQ-012 SHALL have port req_r  input  OUTPUT_SIZE  per-consumer request.
REQ-013 SHALL have port ack_r  output  OUTPUT_SIZE  per-consumer one-cycle acknowledge, registered.
REQ-014 SHALL have port dout  output  DATA_WIDTH  result register.
REQ-015 SHALL have port fire_count  output  32  number of results produced, wraps mod 2^32.

Function
REQ-016 Per input k: synchronous FIFO of DEPTH entries, occupancy counter 0..DEPTH.
REQ-017 Push on input k SHALL occur only at an edge where req_l[k]=1 and ack_l[k]=1; ack_l[k] while req_l[k]=0 SHALL be ignored.
REQ-018 req_l[k] next SHALL be 1 iff no push this edge and post-edge occupancy < DEPTH (one idle cycle after every push).
REQ-019 Fire SHALL occur at an edge where every FIFO is non-empty, no pending bit set, and no ack_r bit high; it pops one entry from each FIFO, loads dout, sets pending[0..OUTPUT_SIZE-1]=1, increments fire_count.
REQ-020 Simultaneous push and pop on one FIFO SHALL leave occupancy unchanged; pushing into a full FIFO SHALL be impossible by REQ-018.
REQ-021 Output j: at an edge where pending[j]=1, req_r[j]=1, ack_r[j]=0: ack_r[j]<=1 for exactly one cycle, pending[j]<=0; consumers served independently, in any order.
REQ-022 dout SHALL be stable from fire until the cycle after the last ack_r pulse ends.
REQ-023 Latency: push at edge e with other FIFOs non-empty and node idle -> fire at e+1 -> earliest ack_r high after e+2.
REQ-024 Op semantics (op_k = FIFO k head, unsigned, truncated mod 2^DATA_WIDTH): reg/in/out = op_0; addi/subi/muli = op_0 +/-/* IMMEDIATE; add = sum; sub = op_0-op_1-op_2; mul = product; min/max = unsigned min/max over all operands.
REQ-025 INPUT_SIZE=1 with a two-operand op, or unknown OP, SHALL give dout = 0 (ops still fire).

Reset
REQ-026 rst=1 SHALL, at the edge, clear all FIFOs, pending, ack_r=0, req_l=0, dout=0, fire_count=0, overriding any concurrent push, fire or ack.
REQ-027 req_l SHALL go to all-ones on the first edge with rst=0; in-flight results at reset are discarded.

Verification
REQ-028 Bench SHALL cover: OP=add, IN=2, OUT=1, producers 0,1,2.. and 100,101..; consumer always requests -> results 100,102,104..., fire_count matches consumer count.
REQ-029 Bench SHALL cover: OUT=2, consumer 1 holds req_r low 20 cycles -> consumer 0 gets one ack only, no second fire, FIFOs fill to DEPTH, req_l drops; release -> both see identical sequence, no loss.
REQ-030 Bench SHALL cover: input 1 producer stalled while input 0 streams -> FIFO0 reaches 4 (DEPTH=4), req_l[0]=0, fire_count=0; input 1 resumes -> pairing in order.
REQ-031 Bench SHALL cover: OP=subi, IMMEDIATE=5, IN=1, operand 3 -> dout = 2^32-2 (wrap); OP=max, IN=3, operands 7,9,2 -> dout=9.
REQ-032 Bench SHALL cover: rst pulsed with FIFOs half full and pending set -> next cycle all outputs 0, then req_l all-ones; first post-reset result uses only post-reset data.

Source files
------------

// File: rtl/elastic_async_operator.sv
// -----------------------------------------------------------------------------
// elastic_async_operator
//
// Elastic dataflow node. Each operand input has a small synchronous FIFO that
// is filled through a pull handshake (req_l out, ack_l in). When every FIFO
// holds data and all consumers have taken the previous result, the node
// "fires": it pops one entry per FIFO, computes OP over the FIFO heads into
// dout, and offers the result to every consumer. Each consumer gets exactly
// one single-cycle ack_r pulse per result and is served independently.
//
// Ports
//   clk         clock, all state on the rising edge
//   rst         synchronous active-high reset
//   req_l       [INPUT_SIZE]   registered pull request to each producer
//   ack_l       [INPUT_SIZE]   producer acknowledge; din slice valid with it
//   din         [DW*IN]        operand k in bits [DW*(k+1)-1 : DW*k]
//   req_r       [OUTPUT_SIZE]  consumer requests
//   ack_r       [OUTPUT_SIZE]  registered one-cycle acknowledge per consumer
//   dout        [DATA_WIDTH]   result register, held until all consumers acked
//   fire_count  [32]           number of results produced, wraps
// -----------------------------------------------------------------------------
module elastic_async_operator #(
  parameter int    DATA_WIDTH  = 32,
  parameter int    INPUT_SIZE  = 2,
  parameter int    OUTPUT_SIZE = 2,
  parameter int    DEPTH       = 4,
  parameter string OP          = "add",
  parameter int    IMMEDIATE   = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic [INPUT_SIZE-1:0]            req_l,
  input  logic [INPUT_SIZE-1:0]            ack_l,
  input  logic [DATA_WIDTH*INPUT_SIZE-1:0] din,
  input  logic [OUTPUT_SIZE-1:0]           req_r,
  output logic [OUTPUT_SIZE-1:0]           ack_r,
  output logic [DATA_WIDTH-1:0]            dout,
  output logic [31:0]                      fire_count
);

  localparam int              PW   = $clog2(DEPTH);
  localparam int              CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]   FULL = CW'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] IMM = DATA_WIDTH'(IMMEDIATE);

  typedef enum logic [3:0] {
    OP_PASS, OP_ADDI, OP_SUBI, OP_MULI,
    OP_ADD,  OP_SUB,  OP_MUL,  OP_MIN, OP_MAX,
    OP_ZERO
  } op_e;

  // Multi-operand ops are meaningless with a single input; they resolve to
  // OP_ZERO so the node still fires but always produces 0.
  localparam bit MULTI_OP = (OP == "add") || (OP == "sub") || (OP == "mul") ||
                            (OP == "min") || (OP == "max");

  localparam op_e OP_SEL =
    (MULTI_OP && INPUT_SIZE == 1)                  ? OP_ZERO :
    (OP == "reg" || OP == "in" || OP == "out")     ? OP_PASS :
    (OP == "addi")                                 ? OP_ADDI :
    (OP == "subi")                                 ? OP_SUBI :
    (OP == "muli")                                 ? OP_MULI :
    (OP == "add")                                  ? OP_ADD  :
    (OP == "sub")                                  ? OP_SUB  :
    (OP == "mul")                                  ? OP_MUL  :
    (OP == "min")                                  ? OP_MIN  :
    (OP == "max")                                  ? OP_MAX  : OP_ZERO;

  logic [INPUT_SIZE-1:0]                 w_push;
  logic [INPUT_SIZE-1:0]                 w_nonempty;
  logic [INPUT_SIZE-1:0][DATA_WIDTH-1:0] w_head;
  logic                                  w_fire;

  logic [OUTPUT_SIZE-1:0] r_pending;
  logic [OUTPUT_SIZE-1:0] r_ack_r;
  logic [DATA_WIDTH-1:0]  r_dout;
  logic [31:0]            r_fire_count;

  logic [DATA_WIDTH-1:0]  w_sum, w_diff, w_prod, w_min, w_max, w_result;

  // A new result may only be produced once every consumer has taken the
  // previous one and its ack pulse has ended; this keeps dout stable.
  assign w_fire = (&w_nonempty) && (r_pending == '0) && (r_ack_r == '0);

  // ---------------------------------------------------------------------------
  // Per-input FIFOs
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < INPUT_SIZE; k++) begin : g_fifo
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wptr, r_rptr;
    logic [CW-1:0]         r_count, w_count_nxt;
    logic                  r_req;

    // ack_l only counts while we are requesting.
    assign w_push[k]     = r_req & ack_l[k];
    assign w_nonempty[k] = (r_count != '0);
    assign w_head[k]     = r_mem[r_rptr];
    assign w_count_nxt   = r_count + CW'(w_push[k]) - CW'(w_fire);
    assign req_l[k]      = r_req;

    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent behaviour.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
        r_req   <= 1'b0;
      end else begin
        if (w_push[k]) r_wptr <= r_wptr + 1'b1;
        if (w_fire)    r_rptr <= r_rptr + 1'b1;
        r_count <= w_count_nxt;
        // Request drops for one cycle after each accepted push and stays low
        // while full, so a push into a full FIFO cannot happen.
        r_req   <= !w_push[k] && (w_count_nxt < FULL);
      end
    end

    // NOTE: storage is deliberately not reset; clearing the pointers and count
    // empties the FIFO, and unreset storage maps onto plain RAM cells.
    always_ff @(posedge clk) begin
      if (w_push[k]) r_mem[r_wptr] <= din[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // ---------------------------------------------------------------------------
  // Reductions over the FIFO heads (unsigned, truncated to DATA_WIDTH)
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before any conditional
  // assignment, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_sum  = '0;
    w_prod = DATA_WIDTH'(1);
    w_diff = w_head[0];
    w_min  = w_head[0];
    w_max  = w_head[0];
    for (int k = 0; k < INPUT_SIZE; k++) begin
      w_sum  = w_sum + w_head[k];
      w_prod = w_prod * w_head[k];
      if (w_head[k] < w_min) w_min = w_head[k];
      if (w_head[k] > w_max) w_max = w_head[k];
      if (k > 0) w_diff = w_diff - w_head[k];
    end
  end

  always_comb begin
    w_result = '0;
    case (OP_SEL)
      OP_PASS: w_result = w_head[0];
      OP_ADDI: w_result = w_head[0] + IMM;
      OP_SUBI: w_result = w_head[0] - IMM;
      OP_MULI: w_result = w_head[0] * IMM;
      OP_ADD:  w_result = w_sum;
      OP_SUB:  w_result = w_diff;
      OP_MUL:  w_result = w_prod;
      OP_MIN:  w_result = w_min;
      OP_MAX:  w_result = w_max;
      default: w_result = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Result register and per-consumer delivery
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout       <= '0;
      r_pending    <= '0;
      r_ack_r      <= '0;
      r_fire_count <= '0;
    end else begin
      if (w_fire) begin
        r_dout       <= w_result;
        r_pending    <= '1;
        r_fire_count <= r_fire_count + 32'd1;
      end
      // Fire requires pending == 0, so it never collides with a delivery.
      for (int j = 0; j < OUTPUT_SIZE; j++) begin
        if (r_pending[j] && req_r[j] && !r_ack_r[j]) begin
          r_ack_r[j]   <= 1'b1;
          r_pending[j] <= 1'b0;
        end else begin
          r_ack_r[j]   <= 1'b0;
        end
      end
    end
  end

  assign ack_r      = r_ack_r;
  assign dout       = r_dout;
  assign fire_count = r_fire_count;

endmodule

// File: tb/tb_elastic_async_operator.sv
// -----------------------------------------------------------------------------
// tb_elastic_async_operator
//
// Two streaming add nodes (one and two consumers) driven by counting
// producers, with a scoreboard that pairs pushed operands in order and queues
// the expected sum for every consumer. Six single-shot nodes cover the
// remaining operators and the single-input corner cases.
// -----------------------------------------------------------------------------
module tb_elastic_async_operator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges, then step off the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Streaming add nodes: index 0 = one consumer, index 1 = two consumers
  // ---------------------------------------------------------------------------
  logic [1:0]  ack_l_a [2];
  logic [63:0] din_a   [2];
  logic [1:0]  req_r_a [2];
  wire  [1:0]  req_l_a [2];
  wire  [1:0]  ack_r_a [2];
  wire  [31:0] dout_a  [2];
  wire  [31:0] fc_a    [2];
  wire         ack_r_one;

  assign ack_r_a[0] = {1'b0, ack_r_one};

  elastic_async_operator #(
    .DATA_WIDTH(32), .INPUT_SIZE(2), .OUTPUT_SIZE(1), .DEPTH(4), .OP("add"), .IMMEDIATE(0)
  ) u_add_o1 (
    .clk(clk), .rst(rst), .req_l(req_l_a[0]), .ack_l(ack_l_a[0]), .din(din_a[0]),
    .req_r(req_r_a[0][0]), .ack_r(ack_r_one), .dout(dout_a[0]), .fire_count(fc_a[0])
  );

  elastic_async_operator #(
    .DATA_WIDTH(32), .INPUT_SIZE(2), .OUTPUT_SIZE(2), .DEPTH(4), .OP("add"), .IMMEDIATE(0)
  ) u_add_o2 (
    .clk(clk), .rst(rst), .req_l(req_l_a[1]), .ack_l(ack_l_a[1]), .din(din_a[1]),
    .req_r(req_r_a[1]), .ack_r(ack_r_a[1]), .dout(dout_a[1]), .fire_count(fc_a[1])
  );

  // ---------------------------------------------------------------------------
  // Single-shot operator nodes
  // ---------------------------------------------------------------------------
  localparam int NOPS = 6;
  logic        op_ack = 1'b0;
  logic        op_req = 1'b1;
  logic [31:0] din1   = 32'd3;
  logic [95:0] din3   = {32'd2, 32'd9, 32'd7};   // operands 7, 9, 2
  wire  [31:0] dout_o [NOPS];
  wire         ack_o  [NOPS];
  wire  [31:0] fc_o   [NOPS];
  wire         rl1    [2];
  wire  [2:0]  rl3    [4];

  elastic_async_operator #(.INPUT_SIZE(1), .OUTPUT_SIZE(1), .OP("subi"), .IMMEDIATE(5)) u_subi (
    .clk(clk), .rst(rst), .req_l(rl1[0]), .ack_l(op_ack), .din(din1),
    .req_r(op_req), .ack_r(ack_o[0]), .dout(dout_o[0]), .fire_count(fc_o[0]));
  elastic_async_operator #(.INPUT_SIZE(1), .OUTPUT_SIZE(1), .OP("add")) u_add_in1 (
    .clk(clk), .rst(rst), .req_l(rl1[1]), .ack_l(op_ack), .din(din1),
    .req_r(op_req), .ack_r(ack_o[1]), .dout(dout_o[1]), .fire_count(fc_o[1]));
  elastic_async_operator #(.INPUT_SIZE(3), .OUTPUT_SIZE(1), .OP("max")) u_max3 (
    .clk(clk), .rst(rst), .req_l(rl3[0]), .ack_l({3{op_ack}}), .din(din3),
    .req_r(op_req), .ack_r(ack_o[2]), .dout(dout_o[2]), .fire_count(fc_o[2]));
  elastic_async_operator #(.INPUT_SIZE(3), .OUTPUT_SIZE(1), .OP("min")) u_min3 (
    .clk(clk), .rst(rst), .req_l(rl3[1]), .ack_l({3{op_ack}}), .din(din3),
    .req_r(op_req), .ack_r(ack_o[3]), .dout(dout_o[3]), .fire_count(fc_o[3]));
  elastic_async_operator #(.INPUT_SIZE(3), .OUTPUT_SIZE(1), .OP("sub")) u_sub3 (
    .clk(clk), .rst(rst), .req_l(rl3[2]), .ack_l({3{op_ack}}), .din(din3),
    .req_r(op_req), .ack_r(ack_o[4]), .dout(dout_o[4]), .fire_count(fc_o[4]));
  elastic_async_operator #(.INPUT_SIZE(3), .OUTPUT_SIZE(1), .OP("mul")) u_mul3 (
    .clk(clk), .rst(rst), .req_l(rl3[3]), .ack_l({3{op_ack}}), .din(din3),
    .req_r(op_req), .ack_r(ack_o[5]), .dout(dout_o[5]), .fire_count(fc_o[5]));

  // ---------------------------------------------------------------------------
  // Producer / consumer models and scoreboard for the streaming nodes
  // ---------------------------------------------------------------------------
  logic [1:0]  prod_en  [2];
  logic [1:0]  cons_en  [2];
  int unsigned prod_val [2][2];
  logic [31:0] in_q     [2][2][$];
  logic [31:0] exp_q    [2][2][$];
  int          acks     [2][2];
  int          n_fired  [2];

  initial begin
    logic [31:0] s;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        // req_l is registered, so a request seen now is the one the DUT uses
        // at the next rising edge; that is when the push happens.
        for (int k = 0; k < 2; k++) begin
          if (!rst && prod_en[i][k] && req_l_a[i][k]) begin
            ack_l_a[i][k]          = 1'b1;
            din_a[i][32*k +: 32]   = prod_val[i][k];
            in_q[i][k].push_back(prod_val[i][k]);
            prod_val[i][k]++;
          end else begin
            ack_l_a[i][k] = 1'b0;
          end
        end
        while (in_q[i][0].size() > 0 && in_q[i][1].size() > 0) begin
          s = in_q[i][0].pop_front() + in_q[i][1].pop_front();
          exp_q[i][0].push_back(s);
          if (i == 1) exp_q[i][1].push_back(s);
          n_fired[i]++;
        end
        for (int j = 0; j < ((i == 0) ? 1 : 2); j++) begin
          if (ack_r_a[i][j]) begin
            acks[i][j]++;
            if (exp_q[i][j].size() == 0) check("ack_without_result", 32'(exp_q[i][j].size()), 32'd1);
            else check($sformatf("dout_n%0d_c%0d", i, j), dout_a[i], exp_q[i][j].pop_front());
          end
        end
        req_r_a[i] = cons_en[i];
      end
    end
  end

  task automatic clear_model();
    for (int i = 0; i < 2; i++) begin
      n_fired[i] = 0;
      for (int k = 0; k < 2; k++) begin
        in_q[i][k].delete();
        exp_q[i][k].delete();
        acks[i][k] = 0;
      end
    end
  endtask

  task automatic drain(input string tag);
    int c = 0;
    while (c < 200 && (exp_q[0][0].size() + exp_q[1][0].size() + exp_q[1][1].size()) != 0) begin
      cyc(1);
      c++;
    end
    check(tag, 32'(exp_q[0][0].size() + exp_q[1][0].size() + exp_q[1][1].size()), 32'd0);
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Scenario sequence
  // ---------------------------------------------------------------------------
  initial begin
    int          fc0, ack0;
    logic [31:0] exp_o [NOPS];
    logic [31:0] got_o [NOPS];
    logic        seen  [NOPS];

    for (int i = 0; i < 2; i++) begin
      prod_en[i]     = 2'b00;
      cons_en[i]     = 2'b00;
      ack_l_a[i]     = 2'b00;
      din_a[i]       = '0;
      req_r_a[i]     = 2'b00;
      prod_val[i][0] = 0;
      prod_val[i][1] = 100;
    end
    clear_model();

    // Reset state, then request on the first edge out of reset.
    cyc(3);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_req_l_n%0d", i), 32'(req_l_a[i]), 32'd0);
      check($sformatf("rst_ack_r_n%0d", i), 32'(ack_r_a[i]), 32'd0);
      check($sformatf("rst_dout_n%0d", i),  dout_a[i], 32'd0);
      check($sformatf("rst_fc_n%0d", i),    fc_a[i],   32'd0);
    end
    rst = 1'b0;
    cyc(1);
    for (int i = 0; i < 2; i++) check($sformatf("req_l_up_n%0d", i), 32'(req_l_a[i]), 32'd3);

    // Continuous streaming: sums 100, 102, 104, ...
    prod_en[0] = 2'b11; prod_en[1] = 2'b11;
    cons_en[0] = 2'b01; cons_en[1] = 2'b11;
    cyc(60);
    prod_en[0] = 2'b00; prod_en[1] = 2'b00;
    drain("stream_drain");
    check("stream_fc_vs_acks", fc_a[0], 32'(acks[0][0]));
    check("stream_fc_vs_model", fc_a[0], 32'(n_fired[0]));
    check("stream_fc_min", 32'(fc_a[0] > 10), 32'd1);

    // Consumer 1 holds off: one delivery to consumer 0, then back-pressure.
    fc0  = fc_a[1];
    ack0 = acks[1][0];
    prod_en[1] = 2'b11;
    cons_en[1] = 2'b01;
    cyc(20);
    check("hold_one_ack_c0", 32'(acks[1][0] - ack0), 32'd1);
    check("hold_one_fire", fc_a[1] - 32'(fc0), 32'd1);
    check("hold_req_l_low", 32'(req_l_a[1]), 32'd0);
    cons_en[1] = 2'b11;
    cyc(10);
    prod_en[1] = 2'b00;
    drain("hold_drain");
    check("hold_same_count", 32'(acks[1][0]), 32'(acks[1][1]));

    // Input 1 stalled: FIFO 0 fills, nothing fires; then pairing resumes.
    fc0 = fc_a[1];
    prod_en[1] = 2'b01;
    cyc(12);
    check("stall_req_l0_low", 32'(req_l_a[1][0]), 32'd0);
    check("stall_req_l1_high", 32'(req_l_a[1][1]), 32'd1);
    check("stall_fifo0_pushes", 32'(in_q[1][0].size()), 32'd4);
    check("stall_no_fire", fc_a[1] - 32'(fc0), 32'd0);
    prod_en[1] = 2'b11;
    cyc(24);
    prod_en[1] = 2'b00;
    drain("stall_drain");

    // Reset mid-flight with data queued and a result pending.
    prod_en[1] = 2'b11;
    cons_en[1] = 2'b01;
    cyc(7);
    rst = 1'b1;
    cyc(1);
    clear_model();
    check("midrst_req_l", 32'(req_l_a[1]), 32'd0);
    check("midrst_ack_r", 32'(ack_r_a[1]), 32'd0);
    check("midrst_dout",  dout_a[1], 32'd0);
    check("midrst_fc",    fc_a[1],   32'd0);
    rst = 1'b0;
    cyc(1);
    check("midrst_req_l_up", 32'(req_l_a[1]), 32'd3);
    cons_en[1] = 2'b11;
    cyc(20);
    prod_en[1] = 2'b00;
    drain("midrst_drain");
    check("midrst_fc_model", fc_a[1], 32'(n_fired[1]));

    // Single-shot operators.
    exp_o[0] = 32'hFFFF_FFFE;   // 3 - 5 wraps
    exp_o[1] = 32'd0;           // add with one input
    exp_o[2] = 32'd9;           // max(7,9,2)
    exp_o[3] = 32'd2;           // min(7,9,2)
    exp_o[4] = 32'hFFFF_FFFC;   // 7 - 9 - 2
    exp_o[5] = 32'd126;         // 7 * 9 * 2
    for (int i = 0; i < NOPS; i++) begin
      seen[i]  = 1'b0;
      got_o[i] = '0;
    end
    op_ack = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      for (int i = 0; i < NOPS; i++) begin
        if (ack_o[i] && !seen[i]) begin
          seen[i]  = 1'b1;
          got_o[i] = dout_o[i];
        end
      end
    end
    for (int i = 0; i < NOPS; i++) begin
      check($sformatf("op%0d_delivered", i), 32'(seen[i]), 32'd1);
      check($sformatf("op%0d_dout", i), got_o[i], exp_o[i]);
    end
    check("op_fired", 32'(fc_o[1] != 0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
